// File: rtl/seg_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture_if
// Brief    : Segment-input / decoded-word handshake bundle for seg_capture.
// Revision : 1.0
// ============================================================================
interface seg_capture_if;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  seg2;
    logic [7:0]  seg3;
    logic [7:0]  seg4;
    logic [7:0]  seg5;
    logic [7:0]  seg6;
    logic [7:0]  seg7;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        err;
    logic [7:0]  err_mask;
    logic        overrun;

    modport master (
        input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, ready,
        output data, valid, err, err_mask, overrun
    );

    modport slave (
        output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, ready,
        input  data, valid, err, err_mask, overrun
    );
endinterface
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture
// Brief    : Debounces eight 7-segment digit patterns and delivers decoded
//            32-bit words through a two-deep valid/ready buffer.
// Revision : 1.0
// ============================================================================
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    seg_capture_if.master  bus
);

    localparam logic [7:0] c_CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CYCLES - 1);

    // Returns {undecodable, nibble}; the dp bit is forced high before lookup.
    function automatic logic [4:0] f_decode(input logic [7:0] s);
        logic [4:0] v;
        case ({s[7:1], 1'b1})
            8'h03:   v = 5'h00;
            8'h9F:   v = 5'h01;
            8'h25:   v = 5'h02;
            8'h0D:   v = 5'h03;
            8'h99:   v = 5'h04;
            8'h49:   v = 5'h05;
            8'h41:   v = 5'h06;
            8'h1F:   v = 5'h07;
            8'h01:   v = 5'h08;
            8'h09:   v = 5'h09;
            8'h11:   v = 5'h0A;
            8'hC1:   v = 5'h0B;
            8'h63:   v = 5'h0C;
            8'h85:   v = 5'h0D;
            8'h61:   v = 5'h0E;
            8'h71:   v = 5'h0F;
            default: v = 5'h10;
        endcase
        return v;
    endfunction

    logic [63:0] w_sample;
    logic [31:0] w_word;
    logic [7:0]  w_mask;
    logic        w_cap;
    logic        w_push;
    logic        w_xfer;

    logic [63:0] r_in_q;
    logic [7:0]  r_cnt;
    logic [31:0] r_out;
    logic        r_out_v;
    logic [31:0] r_pend;
    logic        r_pend_v;
    logic [31:0] r_last;
    logic        r_have;
    logic        r_err;
    logic [7:0]  r_mask;
    logic        r_ovr;

    assign w_sample = {bus.seg7, bus.seg6, bus.seg5, bus.seg4,
                       bus.seg3, bus.seg2, bus.seg1, bus.seg0};

    for (genvar i = 0; i < 8; i++) begin : g_dec
        logic [4:0] w_dec;
        assign w_dec              = f_decode(r_in_q[8*i +: 8]);
        assign w_word[4*i +: 4]   = w_dec[3:0];
        assign w_mask[i]          = w_dec[4];
    end

    // The capture edge is the one that saturates the counter, so a long hold
    // produces exactly one event.
    assign w_cap  = (w_sample == r_in_q) && (r_cnt == c_CNT_LAST);
    assign w_push = w_cap && (w_mask == 8'h00) && (!r_have || (w_word != r_last));
    assign w_xfer = r_out_v && bus.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q   <= '1;
            r_cnt    <= 8'h00;
            r_out    <= 32'h0;
            r_out_v  <= 1'b0;
            r_pend   <= 32'h0;
            r_pend_v <= 1'b0;
            r_last   <= 32'h0;
            r_have   <= 1'b0;
            r_err    <= 1'b0;
            r_mask   <= 8'h00;
            r_ovr    <= 1'b0;
        end else begin
            r_in_q <= w_sample;
            if (w_sample != r_in_q) begin
                r_cnt <= 8'h00;
            end else if (r_cnt < c_CNT_MAX) begin
                r_cnt <= r_cnt + 8'h01;
            end

            r_err <= w_cap && (w_mask != 8'h00);
            if (w_cap) begin
                if (w_mask != 8'h00) begin
                    r_mask <= w_mask;
                end else begin
                    r_mask <= 8'h00;
                    r_last <= w_word;
                    r_have <= 1'b1;
                end
            end

            if (w_push) begin
                if (!r_out_v) begin
                    r_out   <= w_word;
                    r_out_v <= 1'b1;
                end else if (w_xfer) begin
                    if (r_pend_v) begin
                        r_out  <= r_pend;
                        r_pend <= w_word;
                    end else begin
                        r_out  <= w_word;
                    end
                end else begin
                    // Pending slot already occupied means its word is lost.
                    r_pend   <= w_word;
                    r_pend_v <= 1'b1;
                    if (r_pend_v) begin
                        r_ovr <= 1'b1;
                    end
                end
            end else if (w_xfer) begin
                if (r_pend_v) begin
                    r_out    <= r_pend;
                    r_pend_v <= 1'b0;
                end else begin
                    r_out_v  <= 1'b0;
                end
            end
        end
    end

    assign bus.data     = r_out;
    assign bus.valid    = r_out_v;
    assign bus.err      = r_err;
    assign bus.err_mask = r_mask;
    assign bus.overrun  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_capture
// Brief    : Randomised and directed scoreboard bench for seg_capture.
// Revision : 1.0
// ============================================================================
module tb_seg_capture;
    localparam int STABLE = 4;
    localparam logic [7:0] C_SEG [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                          8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_ready = 1'b0;
    logic [7:0] pat [8];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    seg_capture_if bus();
    assign bus.seg0  = pat[0];
    assign bus.seg1  = pat[1];
    assign bus.seg2  = pat[2];
    assign bus.seg3  = pat[3];
    assign bus.seg4  = pat[4];
    assign bus.seg5  = pat[5];
    assign bus.seg6  = pat[6];
    assign bus.seg7  = pat[7];
    assign bus.ready = r_ready;

    seg_capture #(.STABLE_CYCLES(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ---------------- reference model ----------------
    logic [31:0] exp_q [$];
    logic [63:0] m_prev;
    int          m_run, m_cnt;
    logic        m_have, m_err, m_ovr, m_init = 1'b0;
    logic [7:0]  m_mask;
    logic [31:0] m_last;

    function automatic logic [4:0] ref_decode(input logic [7:0] b);
        for (int k = 0; k < 16; k++)
            if ({b[7:1], 1'b1} == C_SEG[k]) return {1'b0, 4'(k)};
        return 5'h10;
    endfunction

    always @(posedge clk) begin : p_model
        logic [63:0] s;
        logic [31:0] w;
        logic [7:0]  mk;
        logic [4:0]  d;
        logic        xf, cap, push;
        s = {pat[7], pat[6], pat[5], pat[4], pat[3], pat[2], pat[1], pat[0]};
        if (rst) begin
            m_prev = '1; m_run = 0; m_cnt = 0; exp_q.delete();
            m_have = 0; m_err = 0; m_mask = 0; m_ovr = 0; m_last = 0; m_init = 1;
        end else if (m_init) begin
            xf  = (m_cnt > 0) && r_ready;
            cap = 0;
            if (s != m_prev) m_run = 0;
            else if (m_run < STABLE) begin
                m_run++;
                cap = (m_run == STABLE);
            end
            m_prev = s;
            m_err = 0;
            push = 0;
            w = 0;
            if (cap) begin
                mk = 0;
                for (int i = 0; i < 8; i++) begin
                    d = ref_decode(s[8*i +: 8]);
                    w[4*i +: 4] = d[3:0];
                    mk[i] = d[4];
                end
                if (mk != 0) begin
                    m_err = 1; m_mask = mk;
                end else begin
                    m_mask = 0;
                    push = !m_have || (w != m_last);
                    m_have = 1; m_last = w;
                end
            end
            if (push) begin
                if (m_cnt == 0) begin exp_q.push_back(w); m_cnt = 1; end
                else if (xf) exp_q.push_back(w);
                else if (m_cnt == 1) begin exp_q.push_back(w); m_cnt = 2; end
                else begin
                    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = w;
                    m_ovr = 1;
                end
            end else if (xf) m_cnt--;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (m_init) begin
            n_vec++;
            if (bus.valid !== (m_cnt > 0)) begin n_err++; $display("FAIL valid: got %b want %b", bus.valid, m_cnt > 0); end
            n_vec++;
            if (bus.err !== m_err) begin n_err++; $display("FAIL err: got %b want %b", bus.err, m_err); end
            n_vec++;
            if (bus.err_mask !== m_mask) begin n_err++; $display("FAIL err_mask: got %h want %h", bus.err_mask, m_mask); end
            n_vec++;
            if (bus.overrun !== m_ovr) begin n_err++; $display("FAIL overrun: got %b want %b", bus.overrun, m_ovr); end
            if (bus.valid === 1'b1 && r_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL xfer: got unexpected word %h want none", bus.data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.data !== e) begin n_err++; $display("FAIL data: got %h want %h", bus.data, e); end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) pat[i] = C_SEG[w[4*i +: 4]];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL %s: got %h want %h", name, got, want); end
    endtask

    initial begin
        logic [31:0] w, prev_w;
        for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
        rst = 1; tick(3); rst = 0;
        chk("reset_data", bus.data, 0);
        chk("reset_valid", 32'(bus.valid), 0);
        chk("reset_mask", 32'(bus.err_mask), 0);

        // Latency: pattern before edge 1, capture visible after edge STABLE+1
        r_ready = 1; set_word(32'h12345678);
        tick(STABLE);
        chk("latency_early", 32'(bus.valid), 0);
        tick(1);
        chk("latency_valid", 32'(bus.valid), 1);
        chk("latency_data", bus.data, 32'h12345678);
        tick(5);

        // Toggle every 3 cycles: never stable long enough
        for (int k = 0; k < 14; k++) begin
            set_word(k[0] ? 32'hAAAA5555 : 32'h01234567);
            tick(3);
        end

        // Undecodable digit 3
        set_word(32'h0); pat[3] = 8'hFF;
        tick(STABLE + 1);
        chk("bad_err", 32'(bus.err), 1);
        chk("bad_mask", 32'(bus.err_mask), 32'h08);
        tick(1);
        chk("bad_err_pulse", 32'(bus.err), 0);
        tick(4);

        // Overrun: A, B, C with consumer stalled
        r_ready = 0;
        set_word(32'hA0A0A0A0); tick(7);
        set_word(32'hB1B1B1B1); tick(7);
        set_word(32'hC2C2C2C2); tick(7);
        chk("ovr_set", 32'(bus.overrun), 1);
        r_ready = 1; tick(6);

        // Long hold, reset, same pattern again
        set_word(32'hDEADBEEF); tick(100);
        rst = 1; tick(1); rst = 0;
        chk("rst_ovr_clr", 32'(bus.overrun), 0);
        tick(12);

        // dp toggling on held pattern: recapture of same word, no new transfer
        for (int i = 0; i < 8; i++) pat[i] = pat[i] & 8'hFE;
        tick(10);
        chk("dp_queue", 32'(exp_q.size()), 0);

        // Randomised phase
        prev_w = 32'hDEADBEEF;
        for (int it = 0; it < 150; it++) begin
            w = ($urandom_range(0, 4) == 0) ? prev_w : $urandom;
            set_word(w);
            if ($urandom_range(0, 5) == 0) pat[$urandom_range(0, 7)] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pat[$urandom_range(0, 7)][0] = 1'b0;
            prev_w = w;
            if ($urandom_range(0, 39) == 0) begin rst = 1; tick(1); rst = 0; end
            for (int c = $urandom_range(1, 9); c > 0; c--) begin
                r_ready = ($urandom_range(0, 2) != 0);
                tick(1);
            end
        end

        // Drain
        r_ready = 1; tick(12);
        chk("drain_queue", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(bus.valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
